// File: rtl/instr_fetch.sv
// Fetch stage: owns instruction memory, registers IR plus valid, squashes wrong-path fetches.
// Optional FETCH_CYCLE_CTR_EN builds the per-program cycle counter; otherwise CycleCount is 0.
module instr_fetch #(
   parameter int         A         = 10,
   parameter int         W         = 9,
   parameter logic [W-1:0] HALT_WORD = 9'h1FF
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         Start,
   input  logic [A-1:0] ProgCtr,
   input  logic         BranchTaken,
   input  logic         LoadEn,
   input  logic [A-1:0] LoadAddr,
   input  logic [W-1:0] LoadData,
   output logic [W-1:0] InstOut,
   output logic         InstValid,
   output logic         Done,
   output logic [15:0]  InstCount,
   output logic [15:0]  CycleCount
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   logic [W-1:0] mem [2**A];
   logic [W-1:0] ir;
   logic         v;
   logic         start_r;
   state_t       state;
   state_t       state_n;
   logic         rise;
   logic         fall;
   logic         halt_hit;
   logic         enter;
   logic         v_n;
   logic [15:0]  inst_cnt;

   assign rise     = !start_r && Start;
   assign fall     = start_r && !Start;
   assign halt_hit = (state == RUN) && v && (ir == HALT_WORD);
   assign enter    = (state == IDLE) && fall;

   // Abort on a new Start request wins over the halt transition.
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: begin
            if (fall)
               state_n = RUN;
         end
         RUN: begin
            if (rise)
               state_n = IDLE;
            else if (halt_hit)
               state_n = HALT;
         end
         HALT: begin
            if (rise)
               state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      v_n = (state_n == RUN) && !fall
         && !BranchTaken && !halt_hit;
   end

   // Memory write is never reset so programs survive a Reset.
   always_ff @(posedge Clk) begin
      if (LoadEn)
         mem[LoadAddr] <= LoadData;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         ir      <= '0;
         v       <= 1'b0;
         start_r <= 1'b0;
         state   <= IDLE;
      end else begin
         ir      <= mem[ProgCtr];
         v       <= v_n;
         start_r <= Start;
         state   <= state_n;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset)
         inst_cnt <= '0;
      else if (enter)
         inst_cnt <= '0;
      else if (v)
         inst_cnt <= inst_cnt + 16'd1;
   end

`ifdef FETCH_CYCLE_CTR_EN
   logic [15:0] cyc_cnt;

   always_ff @(posedge Clk) begin
      if (Reset)
         cyc_cnt <= '0;
      else if (enter)
         cyc_cnt <= '0;
      else if (state == RUN)
         cyc_cnt <= cyc_cnt + 16'd1;
   end

   assign CycleCount = cyc_cnt;
`else
   assign CycleCount = 16'd0;
`endif

   assign InstOut   = ir;
   assign InstValid = v;
   assign Done      = (state == HALT);
   assign InstCount = inst_cnt;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: stimulus queues expected
// instructions, a negedge monitor pops them whenever InstValid is high.
module tb_instr_fetch;

   localparam int A = 10;
   localparam int W = 9;

   logic         Clk;
   logic         Reset;
   logic         Start;
   logic [A-1:0] ProgCtr;
   logic         BranchTaken;
   logic         LoadEn;
   logic [A-1:0] LoadAddr;
   logic [W-1:0] LoadData;
   logic [W-1:0] InstOut;
   logic         InstValid;
   logic         Done;
   logic [15:0]  InstCount;
   logic [15:0]  CycleCount;

   int n_vec = 0;
   int n_miss = 0;
   logic [W-1:0] exp_q[$];

   instr_fetch #(.A(A), .W(W), .HALT_WORD(9'h1FF)) dut (
      .Clk(Clk),
      .Reset(Reset),
      .Start(Start),
      .ProgCtr(ProgCtr),
      .BranchTaken(BranchTaken),
      .LoadEn(LoadEn),
      .LoadAddr(LoadAddr),
      .LoadData(LoadData),
      .InstOut(InstOut),
      .InstValid(InstValid),
      .Done(Done),
      .InstCount(InstCount),
      .CycleCount(CycleCount)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Monitor: every valid instruction must match the head of the queue.
   always @(negedge Clk) begin
      if (InstValid === 1'b1) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_miss++;
            $display("FAIL inst_unexpected: got %h, required no valid instruction", InstOut);
         end else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            if (InstOut !== e) begin
               n_miss++;
               $display("FAIL inst_order: got %h, required %h", InstOut, e);
            end
         end
      end
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] cyc(input logic [15:0] e);
`ifdef FETCH_CYCLE_CTR_EN
      return e;
`else
      return 16'd0 & e;
`endif
   endfunction

   task automatic load(input logic [A-1:0] a, input logic [W-1:0] d);
      LoadEn   = 1'b1;
      LoadAddr = a;
      LoadData = d;
      tick();
      LoadEn   = 1'b0;
   endtask

   // Rise then Fall; after the Fall edge the PC sits at base.
   task automatic start_prog(input logic [A-1:0] base, input string tag);
      Start = 1'b1;
      tick();
      chk({tag, "_done_rise"}, {15'd0, Done}, 16'd0);
      Start = 1'b0;
      tick();
      chk({tag, "_valid_fall"}, {15'd0, InstValid}, 16'd0);
      chk({tag, "_icnt_fall"}, InstCount, 16'd0);
      chk({tag, "_ccnt_fall"}, CycleCount, 16'd0);
      ProgCtr = base;
   endtask

   initial begin
      Reset       = 1'b1;
      Start       = 1'b0;
      ProgCtr     = 10'd5;
      BranchTaken = 1'b0;
      LoadEn      = 1'b1;
      LoadAddr    = 10'd5;
      LoadData    = 9'h000;
      tick();
      LoadEn = 1'b0;
      tick();
      chk("rst_instout", {7'd0, InstOut}, 16'd0);
      chk("rst_valid", {15'd0, InstValid}, 16'd0);
      Reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("idle_valid", {15'd0, InstValid}, 16'd0);
         chk("idle_done", {15'd0, Done}, 16'd0);
         chk("idle_instout", {7'd0, InstOut}, 16'd0);
         chk("idle_icnt", InstCount, 16'd0);
         chk("idle_ccnt", CycleCount, 16'd0);
      end

      load(10'd0, 9'h011);
      load(10'd1, 9'h022);
      load(10'd2, 9'h033);
      load(10'd3, 9'h1FF);
      load(10'd200, 9'h0AA);
      load(10'd201, 9'h0BB);
      load(10'd202, 9'h1FF);
      load(10'd203, 9'h0CC);

      // Straight-line program at 0.
      exp_q.push_back(9'h011);
      exp_q.push_back(9'h022);
      exp_q.push_back(9'h033);
      exp_q.push_back(9'h1FF);
      start_prog(10'd0, "p1");
      for (int i = 1; i <= 4; i++) begin
         tick();
         ProgCtr = ProgCtr + 10'd1;
      end
      tick();
      chk("p1_done", {15'd0, Done}, 16'd1);
      chk("p1_valid_halt", {15'd0, InstValid}, 16'd0);
      chk("p1_icnt", InstCount, 16'd4);
      chk("p1_ccnt", CycleCount, cyc(16'd5));
      chk("p1_q_empty", 16'(exp_q.size()), 16'd0);

      // Branch with one bubble, then branch ignored on halt word.
      exp_q.push_back(9'h011);
      exp_q.push_back(9'h022);
      exp_q.push_back(9'h0AA);
      exp_q.push_back(9'h0BB);
      exp_q.push_back(9'h1FF);
      start_prog(10'd0, "p2");
      tick();
      ProgCtr = 10'd1;
      tick();
      chk("p2_inst_022", {7'd0, InstOut}, 16'h022);
      ProgCtr     = 10'd2;
      BranchTaken = 1'b1;
      tick();
      chk("p2_bubble", {15'd0, InstValid}, 16'd0);
      ProgCtr     = 10'd200;
      BranchTaken = 1'b0;
      tick();
      ProgCtr = 10'd201;
      tick();
      ProgCtr = 10'd202;
      tick();
      chk("p2_halt_word", {7'd0, InstOut}, 16'h1FF);
      ProgCtr     = 10'd203;
      BranchTaken = 1'b1;
      tick();
      BranchTaken = 1'b0;
      chk("p2_done", {15'd0, Done}, 16'd1);
      chk("p2_icnt", InstCount, 16'd5);
      chk("p2_ccnt", CycleCount, cyc(16'd7));
      tick();
      tick();
      chk("p2_held_icnt", InstCount, 16'd5);
      chk("p2_q_empty", 16'(exp_q.size()), 16'd0);

      // Program at 200 from HALT.
      exp_q.push_back(9'h0AA);
      exp_q.push_back(9'h0BB);
      exp_q.push_back(9'h1FF);
      start_prog(10'd200, "p3");
      for (int i = 1; i <= 3; i++) begin
         tick();
         ProgCtr = ProgCtr + 10'd1;
      end
      tick();
      chk("p3_done", {15'd0, Done}, 16'd1);
      chk("p3_icnt", InstCount, 16'd3);
      chk("p3_ccnt", CycleCount, cyc(16'd4));

      // Reset after three valid instructions, with a write on the reset edge.
      exp_q.push_back(9'h011);
      exp_q.push_back(9'h022);
      exp_q.push_back(9'h033);
      start_prog(10'd0, "p4");
      for (int i = 1; i <= 3; i++) begin
         tick();
         ProgCtr = ProgCtr + 10'd1;
      end
      @(negedge Clk);
      #1;
      Reset    = 1'b1;
      LoadEn   = 1'b1;
      LoadAddr = 10'd2;
      LoadData = 9'h044;
      tick();
      Reset  = 1'b0;
      LoadEn = 1'b0;
      chk("p4_rst_valid", {15'd0, InstValid}, 16'd0);
      chk("p4_rst_done", {15'd0, Done}, 16'd0);
      chk("p4_rst_instout", {7'd0, InstOut}, 16'd0);
      chk("p4_rst_icnt", InstCount, 16'd0);
      chk("p4_rst_ccnt", CycleCount, 16'd0);
      chk("p4_q_empty", 16'(exp_q.size()), 16'd0);

      // Memory retained across reset; the write during reset landed.
      exp_q.push_back(9'h011);
      exp_q.push_back(9'h022);
      exp_q.push_back(9'h044);
      exp_q.push_back(9'h1FF);
      ProgCtr = 10'd7;
      start_prog(10'd0, "p5");
      for (int i = 1; i <= 4; i++) begin
         tick();
         ProgCtr = ProgCtr + 10'd1;
      end
      tick();
      chk("p5_done", {15'd0, Done}, 16'd1);
      chk("p5_icnt", InstCount, 16'd4);
      chk("p5_ccnt", CycleCount, cyc(16'd5));
      tick();
      tick();
      chk("p5_q_empty", 16'(exp_q.size()), 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Fetch stage directly downstream of the program counter. It owns the instruction memory and samples the PC every cycle with a synchronous read, then presents a registered instruction plus a valid bit to decode. Wrong-path fetches after a taken branch and after a program start are squashed. The stage also detects the halt word, raises `Done`, and keeps per-program instruction and cycle counts for the test bench.

## Interface
Parameters:
- `A`, 10: instruction-memory address bits; the memory holds 2^A words.
- `W`, 9: instruction width in bits.
- `HALT_WORD`, 9'h1FF: encoding that ends the current program.

Ports:
- `Clk`  in  1: the single clock; all state changes on posedge.
- `Reset`  in  1: synchronous, active-high; takes effect at the posedge where it is sampled high.
- `Start`  in  1: test-bench program request, the same signal the PC sees.
- `ProgCtr`  in  A: current PC value.
- `BranchTaken`  in  1: decode's `BranchRelEn && ALU_flag` for the instruction currently on `InstOut`.
- `LoadEn`  in  1: instruction-memory write enable.
- `LoadAddr`  in  A: write address.
- `LoadData`  in  W: write data.
- `InstOut`  out  W: registered instruction.
- `InstValid`  out  1: `InstOut` is a valid, on-path instruction.
- `Done`  out  1: the current program has reached `HALT_WORD`.
- `InstCount`  out  16: valid instructions presented in the current program.
- `CycleCount`  out  16: cycles spent in RUN in the current program.

## Operation
- Memory: 2^A x W, with one synchronous read port and one synchronous write port.
  - Every posedge: `IR <= mem[ProgCtr]`.
  - When `LoadEn`: `mem[LoadAddr] <= LoadData`, accepted in any state.
  - Same-address read and write on one edge: the read returns the old data.
- Start edge detect: `start_r <= Start`.
  - Rise = `!start_r && Start`.
  - Fall = `start_r && !Start`. This is the same edge on which the PC loads the program base.
- FSM states: IDLE, RUN, HALT. `Reset` forces IDLE.
  - IDLE -> RUN on Fall.
  - RUN -> HALT at the edge after `InstValid && InstOut == HALT_WORD`.
  - HALT -> IDLE on Rise.
  - RUN -> IDLE on Rise (abort).
  - All other cases: hold state.
- Valid bit `v`, registered alongside `IR`. It is set to 1 at an edge only if all of the following hold:
  - the state after the edge is RUN;
  - the edge is not the Fall edge;
  - `BranchTaken` is low at that edge;
  - the halt condition is not being taken at that edge.
  - Otherwise `v` is set to 0.
- `InstOut = IR`. `InstValid = v`. `Done = (state == HALT)`.
- Counters:
  - Both clear to 0 on the Fall edge that enters RUN.
  - `CycleCount` increments on each edge while in RUN.
  - `InstCount` increments on each edge where `InstValid` is 1. The HALT word itself is counted.
  - Both hold in HALT and IDLE.
  - Both wrap modulo 2^16.

## Timing
- Read latency is 1 cycle. PC value p at edge t appears on `InstOut` during cycle t+1.
- First instruction after start:
  - At the Fall edge, `InstValid` = 0 (the old PC was fetched).
  - At the next edge, `mem[base]` is loaded with `InstValid` = 1.
- Taken branch: `BranchTaken` high at edge t squashes the fetch of PC+1 at that edge. `mem[target]` becomes valid at edge t+1. Penalty is exactly 1 bubble.
- `BranchTaken` while `InstValid` = 0 still squashes the fetch at that edge.
- `BranchTaken` is ignored when the current valid instruction is `HALT_WORD`; halt takes precedence.
- Reset values: `IR` = 0, `v` = 0, state = IDLE, `start_r` = 0, both counters = 0. Therefore `InstOut` = 0, `InstValid` = 0, `Done` = 0 on the cycle after the Reset edge.
- Reset mid-RUN: at that edge, everything is cleared and the memory contents are retained.
- Simultaneous `Reset` and `LoadEn`: the write still occurs; the memory is not reset.
- PC wrap from 2^A-1 to 0 is fetched normally; this block does no bounds checking.

## Configuration
- `FETCH_CYCLE_CTR_EN`:
  - Defined: `CycleCount` is implemented exactly as above.
  - Undefined: the counter register is not built and `CycleCount` is tied to 0.
  - `InstCount` and all other behaviour are identical in both builds.

## Test plan
- Reset held 2 cycles, then released with no Start -> `InstValid` = 0, `Done` = 0, `InstOut` = 0, counts = 0 for 10 cycles.
- Load mem[0..3] = 9'h011, 9'h022, 9'h033, 9'h1FF; pulse Start; PC at 0 from the Fall edge -> `InstValid` = 0 on the Fall edge; then 011, 022, 033, 1FF valid on consecutive cycles; `Done` = 1 on the next cycle; `InstCount` = 4; `CycleCount` = 5.
- `BranchTaken` high while `InstOut` = 022 at PC 1, PC jumps to 200 with mem[200] = 9'h0AA -> one bubble with `InstValid` = 0, then 0AA valid; `InstCount` excludes the bubble.
- `BranchTaken` asserted with `InstOut` = `HALT_WORD` -> HALT entered and no further valid instruction.
- Second Start while in HALT -> Rise clears `Done`; the Fall edge clears counts; the program at 200 runs with the same 1-cycle start bubble.
- Reset mid-RUN after 3 valid instructions -> next cycle `InstValid` = 0, `Done` = 0, counts = 0; memory still holds the loaded words (verified by a second Start).
